negacyclic_conv_stream_adapter: RTL and testbench

Serial-to-parallel front end and parallel-to-serial back end for the flat-bus negacyclic convolution core. It accepts operand coefficient pairs one per handshake and packs them into the D*N-bit a/b buses. It waits a fixed core latency, then captures the D*N-bit product bus. It streams the product back out one coefficient per handshake. This is the producer and consumer of the core's flat-bus interface, sitting between the streaming datapath and the multiplier.

---
 rtl/negacyclic_conv_stream_adapter_pkg.sv | 22 ++
 rtl/negacyclic_conv_stream_adapter_if.sv | 42 ++++
 rtl/negacyclic_conv_stream_adapter_coef_slot_counter.sv | 34 +++
 rtl/negacyclic_conv_stream_adapter.sv | 114 +++++++++++
 tb/tb_negacyclic_conv_stream_adapter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/negacyclic_conv_stream_adapter_pkg.sv
// Shared types and helpers for the negacyclic convolution stream adapter.
// Optional framing (in_last/out_last/err_len) is enabled by CONV_STREAM_LAST_EN.
package conv_stream_pkg;

  localparam int N_DEF   = 17;
  localparam int D_DEF   = 32;
  localparam int LAT_DEF = 2;
  localparam int IDX_W   = (D_DEF > 1) ? $clog2(D_DEF) : 1;
  localparam int LAT_W   = (LAT_DEF > 1) ? $clog2(LAT_DEF) : 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

  // Bit offset of coefficient slot idx in a flat D*N bus.
  function automatic int slot_off(input int idx, input int n);
    return idx * n;
  endfunction

endpackage

// File: rtl/negacyclic_conv_stream_adapter_if.sv
// Streaming and flat-bus signals of the adapter, grouped with master (adapter) and slave (environment) views.
// Framing signals exist only when CONV_STREAM_LAST_EN is defined.
interface negacyclic_conv_stream_adapter_if #(
  parameter int N = 17,
  parameter int D = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [D*N-1:0] conv_a;
  logic [D*N-1:0] conv_b;
  logic [D*N-1:0] conv_p;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_p;
  logic           busy;
`ifdef CONV_STREAM_LAST_EN
  logic           in_last;
  logic           out_last;
  logic           err_len;
`endif

  modport master (
    input  in_valid, in_a, in_b, conv_p, out_ready,
`ifdef CONV_STREAM_LAST_EN
    input  in_last,
    output out_last, err_len,
`endif
    output in_ready, conv_a, conv_b, out_valid, out_p, busy
  );

  modport slave (
    output in_valid, in_a, in_b, conv_p, out_ready,
`ifdef CONV_STREAM_LAST_EN
    output in_last,
    input  out_last, err_len,
`endif
    input  in_ready, conv_a, conv_b, out_valid, out_p, busy
  );

endinterface

// File: rtl/negacyclic_conv_stream_adapter_coef_slot_counter.sv
// Coefficient slot index shared by the load and unload phases; wraps at D-1.
module coef_slot_counter #(
  parameter int D     = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  assign tc_o  = (idx_q == IDX_W'(D - 1));
  assign idx_o = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)
      idx_d = '0;
    else if (inc_i)
      idx_d = tc_o ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

endmodule

// File: rtl/negacyclic_conv_stream_adapter.sv
// Packs streamed coefficient pairs onto the core's flat a/b buses, waits LAT cycles, then streams the product out.
// Define CONV_STREAM_LAST_EN to add in_last/out_last framing and the sticky err_len flag.
module negacyclic_conv_stream_adapter
  import conv_stream_pkg::*;
#(
  parameter int N   = 17,
  parameter int D   = 32,
  parameter int LAT = 2
) (
  input logic                              clk,
  input logic                              rst_n,
  negacyclic_conv_stream_adapter_if.master bus
);

  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e         state_q, state_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [D*N-1:0] a_q, b_q, p_q;
  logic [IW-1:0]  idx;
  logic           tc;
  logic           load_acc, unload_xfer, force_end, capture;

  assign load_acc    = (state_q == LOAD) && bus.in_valid;
  assign unload_xfer = (state_q == UNLOAD) && bus.out_ready;
  assign capture     = (state_q == WAIT) && (lat_q == '0);

`ifdef CONV_STREAM_LAST_EN
  logic err_q;
  // An early in_last closes the frame short; remaining slots keep stale data.
  assign force_end = load_acc && bus.in_last && !tc;
`else
  assign force_end = 1'b0;
`endif

  coef_slot_counter #(.D(D), .IDX_W(IW)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (load_acc || unload_xfer),
    .clr_i (force_end),
    .idx_o (idx),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      LOAD: begin
        if (load_acc && (tc || force_end)) begin
          state_d = WAIT;
          lat_d   = LW'(LAT - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0)
          state_d = UNLOAD;
        else
          lat_d = lat_q - LW'(1);
      end
      UNLOAD: begin
        if (unload_xfer && tc)
          state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      if (load_acc) begin
        a_q[slot_off(int'(idx), N) +: N] <= bus.in_a;
        b_q[slot_off(int'(idx), N) +: N] <= bus.in_b;
      end
      if (capture)
        p_q <= bus.conv_p;
    end
  end

`ifdef CONV_STREAM_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (force_end)
      err_q <= 1'b1;
  end

  assign bus.out_last = (state_q == UNLOAD) && tc;
  assign bus.err_len  = err_q;
`endif

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == UNLOAD);
  assign bus.out_p     = p_q[slot_off(int'(idx), N) +: N];
  assign bus.busy      = (state_q != LOAD) || (idx != '0);
  assign bus.conv_a    = a_q;
  assign bus.conv_b    = b_q;

endmodule

// File: tb/tb_negacyclic_conv_stream_adapter.sv
// Self-checking bench: XOR stand-in for the convolution core, slot-array model of the packed buses.
// Exercises the framing checks as well when CONV_STREAM_LAST_EN is defined.
module tb_negacyclic_conv_stream_adapter;
  import conv_stream_pkg::*;

  localparam int N   = 17;
  localparam int D   = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  negacyclic_conv_stream_adapter_if #(.N(N), .D(D)) bus ();

  negacyclic_conv_stream_adapter #(.N(N), .D(D), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Core stand-in: the adapter's conv_a/conv_b register plus this one register give LAT=2.
  logic [D*N-1:0] core_q;
  always @(posedge clk) core_q <= bus.conv_a ^ bus.conv_b;
  assign bus.conv_p = core_q;

  int errs = 0;
  int checks = 0;
  logic [N-1:0] opa [D];
  logic [N-1:0] opb [D];
  logic [N-1:0] mem_a [D];
  logic [N-1:0] mem_b [D];
  int last_at = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag);
    for (int k = 0; k < D; k++) begin
      check($sformatf("%s_a[%0d]", tag, k), 64'(bus.conv_a[k*N +: N]), 64'(mem_a[k]));
      check($sformatf("%s_b[%0d]", tag, k), 64'(bus.conv_b[k*N +: N]), 64'(mem_b[k]));
    end
  endtask

  task automatic rand_ops();
    for (int k = 0; k < D; k++) begin
      opa[k] = N'($urandom);
      opb[k] = N'($urandom);
    end
  endtask

  task automatic load(input int n_acc, input int gap);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < n_acc) begin
      bus.in_valid = (cyc % gap == 0);
      bus.in_a = bus.in_valid ? opa[i] : N'($urandom);
      bus.in_b = bus.in_valid ? opb[i] : N'($urandom);
`ifdef CONV_STREAM_LAST_EN
      bus.in_last = (i == last_at);
`endif
      if (bus.in_valid && bus.in_ready) begin
        mem_a[i] = opa[i];
        mem_b[i] = opb[i];
        i++;
      end
      tick();
      cyc++;
      if (cyc > 8 * D) begin
        checks++;
        assert (i == n_acc) else begin
          errs++;
          $error("FAIL load_budget: accepted %0d expected %0d", i, n_acc);
        end
        break;
      end
    end
    bus.in_valid = 1'b0;
`ifdef CONV_STREAM_LAST_EN
    bus.in_last = 1'b0;
`endif
  endtask

  task automatic unload(input int n_xfer, input bit bp);
    int k;
    int cyc;
    int lat;
    k = 0;
    cyc = 0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      check("wait_in_ready", 64'(bus.in_ready), 64'(0));
      check("wait_busy", 64'(bus.busy), 64'(1));
      bus.in_valid = 1'b1;
      bus.in_a = N'($urandom);
      bus.in_b = N'($urandom);
      tick();
      lat++;
    end
    check("first_out_latency", 64'(lat), 64'(LAT + 1));
    while (k < n_xfer && cyc < 6 * D) begin
      bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = N'($urandom);
      bus.in_b = N'($urandom);
      check("unload_in_ready", 64'(bus.in_ready), 64'(0));
      check("unload_out_valid", 64'(bus.out_valid), 64'(1));
      check($sformatf("out_p[%0d]", k), 64'(bus.out_p), 64'(mem_a[k] ^ mem_b[k]));
`ifdef CONV_STREAM_LAST_EN
      check($sformatf("out_last[%0d]", k), 64'(bus.out_last), 64'(k == D - 1));
`endif
      if (bus.out_valid && bus.out_ready) k++;
      tick();
      cyc++;
    end
    checks++;
    assert (k == n_xfer) else begin
      errs++;
      $error("FAIL unload_budget: transferred %0d expected %0d", k, n_xfer);
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    if (n_xfer == D) begin
      check("done_out_valid", 64'(bus.out_valid), 64'(0));
      check("done_in_ready", 64'(bus.in_ready), 64'(1));
      check("done_busy", 64'(bus.busy), 64'(0));
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < D; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_out_p"}, 64'(bus.out_p), 64'(0));
`ifdef CONV_STREAM_LAST_EN
    check({tag, "_err_len"}, 64'(bus.err_len), 64'(0));
`endif
    check_bus(tag);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
`ifdef CONV_STREAM_LAST_EN
    bus.in_last = 1'b0;
`endif
    #3;
    do_reset("reset");

    for (int k = 0; k < D; k++) begin
      opa[k] = N'(k);
      opb[k] = N'(17'h10000);
    end
    load(D, 1);
    check("post_load_in_ready", 64'(bus.in_ready), 64'(0));
    check_bus("ramp");
    unload(D, 1'b0);

    rand_ops();
    load(D, 1);
    unload(D, 1'b1);

    rand_ops();
    load(D, 3);
    check_bus("gap_load");
    unload(D, 1'b0);
    check_bus("gap_hold");

    rand_ops();
    load(15, 1);
    check("mid_load_busy", 64'(bus.busy), 64'(1));
    do_reset("rst_load");
    rand_ops();
    load(D, 1);
    unload(D, 1'b0);

    rand_ops();
    load(D, 1);
    unload(7, 1'b0);
    do_reset("rst_unload");
    rand_ops();
    load(D, 1);
    unload(D, 1'b1);

    rand_ops();
    load(D, 1);
    unload(D, 1'b0);
    rand_ops();
    load(D, 1);
    check_bus("b2b");
    unload(D, 1'b0);

`ifdef CONV_STREAM_LAST_EN
    rand_ops();
    last_at = 19;
    load(20, 1);
    last_at = -1;
    check("short_err_len", 64'(bus.err_len), 64'(1));
    check("short_in_ready", 64'(bus.in_ready), 64'(0));
    unload(D, 1'b0);
    check("err_len_sticky", 64'(bus.err_len), 64'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
